eigen_sequencer: RTL and testbench

EIGEN_SEQUENCER -- requirements
Module: eigen_sequencer

---
 rtl/eigen_sequencer.sv | 165 ++++++++++++++++
 tb/tb_eigen_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eigen_sequencer.sv
// Control sequencer for power-iteration eigen-decomposition: steps the datapath engines through
// INIT, NUM_ITER multiply/normalise rounds, eigenvalue and deflation for each component.
module eigen_sequencer #(
    parameter int unsigned NUM_COMP = 4,
    parameter int unsigned NUM_ITER = 16,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            start,
    output logic                                            load_init,
    output logic                                            mv_start,
    input  logic                                            mv_f,
    output logic                                            norm_start,
    input  logic                                            norm_f,
    output logic                                            eig_start,
    input  logic                                            eig_f,
    output logic                                            defl_start,
    input  logic                                            defl_f,
    output logic                                            eig_valid,
    output logic [(NUM_COMP > 1 ? $clog2(NUM_COMP) : 1)-1:0] comp_idx,
    output logic [(NUM_ITER > 1 ? $clog2(NUM_ITER) : 1)-1:0] iter_idx,
    output logic                                            busy,
    output logic                                            done,
    output logic                                            err
);

    localparam int unsigned CW = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1;
    localparam int unsigned IW = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] COMP_LAST = CW'(NUM_COMP - 1);
    localparam logic [IW-1:0] ITER_LAST = IW'(NUM_ITER - 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StInit = 3'd1;
    localparam logic [2:0] StMv   = 3'd2;
    localparam logic [2:0] StNorm = 3'd3;
    localparam logic [2:0] StEig  = 3'd4;
    localparam logic [2:0] StDefl = 3'd5;
    localparam logic [2:0] StDone = 3'd6;
    localparam logic [2:0] StErr  = 3'd7;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] comp_q, comp_d;
    logic [IW-1:0] iter_q, iter_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          hs_q, hs_d;        // start of the current engine phase is asserted
    logic          valid_q, valid_d;
    logic          start_prev_q;
    logic          engine_f;

    always_comb begin
        case (state_q)
            StMv:    engine_f = mv_f;
            StNorm:  engine_f = norm_f;
            StEig:   engine_f = eig_f;
            StDefl:  engine_f = defl_f;
            default: engine_f = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        comp_d  = comp_q;
        iter_d  = iter_q;
        wdog_d  = wdog_q;
        hs_d    = hs_q;
        valid_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (start && !start_prev_q) begin
                    state_d = StInit;
                    comp_d  = '0;
                    iter_d  = '0;
                end
            end
            StInit: begin
                state_d = StMv;
                wdog_d  = '0;
                hs_d    = 1'b0;
            end
            StMv, StNorm, StEig, StDefl: begin
                wdog_d = wdog_q + 1'b1;
                if (hs_q && engine_f) begin
                    hs_d   = 1'b0;
                    wdog_d = '0;
                    case (state_q)
                        StMv: state_d = StNorm;
                        StNorm: begin
                            if (iter_q != ITER_LAST) begin
                                iter_d  = iter_q + 1'b1;
                                state_d = StMv;
                            end else begin
                                state_d = StEig;
                            end
                        end
                        StEig: begin
                            valid_d = 1'b1;
                            state_d = (comp_q != COMP_LAST) ? StDefl : StDone;
                        end
                        default: begin
                            comp_d  = comp_q + 1'b1;
                            iter_d  = '0;
                            state_d = StInit;
                        end
                    endcase
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = StErr;
                    hs_d    = 1'b0;
                end else if (!hs_q && !engine_f) begin
                    // a finish flag still high from the previous request holds off the new one
                    hs_d = 1'b1;
                end
            end
            StDone, StErr: begin
                if (!start) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (busy && !start) begin
            state_d = StIdle;
            hs_d    = 1'b0;
            valid_d = 1'b0;
            wdog_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            comp_q       <= '0;
            iter_q       <= '0;
            wdog_q       <= '0;
            hs_q         <= 1'b0;
            valid_q      <= 1'b0;
            // forces a fresh low-to-high start after reset even if start is already high
            start_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            comp_q       <= comp_d;
            iter_q       <= iter_d;
            wdog_q       <= wdog_d;
            hs_q         <= hs_d;
            valid_q      <= valid_d;
            start_prev_q <= start;
        end
    end

    assign load_init  = (state_q == StInit);
    assign mv_start   = hs_q && (state_q == StMv);
    assign norm_start = hs_q && (state_q == StNorm);
    assign eig_start  = hs_q && (state_q == StEig);
    assign defl_start = hs_q && (state_q == StDefl);
    assign eig_valid  = valid_q;
    assign comp_idx   = comp_q;
    assign iter_idx   = iter_q;
    assign busy       = (state_q != StIdle) && (state_q != StDone) && (state_q != StErr);
    assign done       = (state_q == StDone);
    assign err        = (state_q == StErr);

endmodule

// File: tb/tb_eigen_sequencer.sv
// Bench for eigen_sequencer: responding engine models, an expected-event queue built from the
// per-component sequence rules, and a per-cycle compare process on handshake invariants.
module tb_eigen_sequencer;

    localparam int EV_LOAD = 0, EV_MV = 1, EV_NORM = 2, EV_EIG = 3, EV_DEFL = 4, EV_VALID = 5;

    typedef struct { int d; int kind; int comp; int iter; } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start_a, start_b;
    logic a_load, a_mv_s, a_norm_s, a_eig_s, a_defl_s, a_valid, a_busy, a_done, a_err;
    logic b_load, b_mv_s, b_norm_s, b_eig_s, b_defl_s, b_valid, b_busy, b_done, b_err;
    logic [0:0] a_comp, b_comp, b_iter;
    logic [1:0] a_iter;

    logic [3:0] fb [2] = '{default: '0};
    logic [3:0] st [2];
    logic       ld [2], vl [2], bz [2], dn [2], er [2];
    int         ci [2], ii [2];

    int lat [2][4];
    int hold_len [2][4];
    bit never [2][4];
    int cnt [2][4] = '{default: 0};
    int hcnt [2][4] = '{default: 0};

    ev_t        exp_q [$];
    int         checks = 0, errors = 0;
    int         cyc = 0, push_n = 0, norm_entry = 0, err_rise = 0;
    int         evcnt [2][6];
    int         done_rises [2];
    logic [3:0] st_p [2] = '{default: '0};
    logic [3:0] f_p [2] = '{default: '0};
    logic       dn_p [2] = '{default: 1'b0};
    logic       er_p [2] = '{default: 1'b0};

    eigen_sequencer #(.NUM_COMP(2), .NUM_ITER(3), .TIMEOUT(20)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .load_init(a_load),
        .mv_start(a_mv_s), .mv_f(fb[0][0]), .norm_start(a_norm_s), .norm_f(fb[0][1]),
        .eig_start(a_eig_s), .eig_f(fb[0][2]), .defl_start(a_defl_s), .defl_f(fb[0][3]),
        .eig_valid(a_valid), .comp_idx(a_comp), .iter_idx(a_iter),
        .busy(a_busy), .done(a_done), .err(a_err)
    );

    eigen_sequencer #(.NUM_COMP(1), .NUM_ITER(1), .TIMEOUT(20)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .load_init(b_load),
        .mv_start(b_mv_s), .mv_f(fb[1][0]), .norm_start(b_norm_s), .norm_f(fb[1][1]),
        .eig_start(b_eig_s), .eig_f(fb[1][2]), .defl_start(b_defl_s), .defl_f(fb[1][3]),
        .eig_valid(b_valid), .comp_idx(b_comp), .iter_idx(b_iter),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    always_comb begin
        st[0] = {a_defl_s, a_eig_s, a_norm_s, a_mv_s};
        st[1] = {b_defl_s, b_eig_s, b_norm_s, b_mv_s};
        ld[0] = a_load;  vl[0] = a_valid; bz[0] = a_busy; dn[0] = a_done; er[0] = a_err;
        ld[1] = b_load;  vl[1] = b_valid; bz[1] = b_busy; dn[1] = b_done; er[1] = b_err;
        ci[0] = int'(a_comp);
        ii[0] = int'(a_iter);
        ci[1] = int'(b_comp);
        ii[1] = int'(b_iter);
    end

    // Engine models: finish flag rises lat cycles after start, falls hold_len cycles after start drops
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int e = 0; e < 4; e++) begin
                if (st[d][e] && !fb[d][e]) begin
                    cnt[d][e]  <= cnt[d][e] + 1;
                    hcnt[d][e] <= 0;
                    if (!never[d][e] && cnt[d][e] + 1 >= lat[d][e]) fb[d][e] <= 1'b1;
                end else if (!st[d][e] && fb[d][e]) begin
                    cnt[d][e] <= 0;
                    if (hcnt[d][e] >= hold_len[d][e]) begin
                        fb[d][e]   <= 1'b0;
                        hcnt[d][e] <= 0;
                    end else begin
                        hcnt[d][e] <= hcnt[d][e] + 1;
                    end
                end else if (!st[d][e]) begin
                    cnt[d][e]  <= 0;
                    hcnt[d][e] <= 0;
                end
            end
        end
    end

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input int d, input int kind, input int c, input int i, input int keep);
        ev_t e;
        if (keep < 0 || push_n < keep) begin
            e.d = d; e.kind = kind; e.comp = c; e.iter = i;
            exp_q.push_back(e);
        end
        push_n++;
    endtask

    // Expected event order for one run, optionally truncated to the first keep events
    task automatic build(input int d, input int nc, input int ni, input int keep);
        push_n = 0;
        for (int c = 0; c < nc; c++) begin
            push(d, EV_LOAD, c, 0, keep);
            for (int i = 0; i < ni; i++) begin
                push(d, EV_MV, c, i, keep);
                push(d, EV_NORM, c, i, keep);
            end
            push(d, EV_EIG, c, ni - 1, keep);
            push(d, EV_VALID, c, ni - 1, keep);
            if (c < nc - 1) push(d, EV_DEFL, c, ni - 1, keep);
        end
    endtask

    task automatic clear();
        exp_q.delete();
        for (int d = 0; d < 2; d++) begin
            done_rises[d] = 0;
            for (int k = 0; k < 6; k++) evcnt[d][k] = 0;
        end
    endtask

    task automatic event_seen(input int d, input int kind);
        ev_t e;
        evcnt[d][kind]++;
        if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_event", d * 10 + kind, -1);
            return;
        end
        e = exp_q.pop_front();
        chk(e.d == d && e.kind == kind, "event_kind", d * 10 + kind, e.d * 10 + e.kind);
        chk(ci[d] == e.comp, "event_comp_idx", ci[d], e.comp);
        chk(ii[d] == e.iter, "event_iter_idx", ii[d], e.iter);
        if (kind != EV_VALID) chk(bz[d] == 1'b1, "busy_in_phase", int'(bz[d]), 1);
    endtask

    task automatic observe(input int d);
        if (ld[d]) event_seen(d, EV_LOAD);
        for (int e = 0; e < 4; e++) begin
            if (st[d][e] && !st_p[d][e]) begin
                chk(!f_p[d][e], "start_rise_with_f_high", int'(f_p[d][e]), 0);
                event_seen(d, e + 1);
            end
            if (st_p[d][e] && f_p[d][e]) chk(!st[d][e], "start_held_after_f", int'(st[d][e]), 0);
        end
        if (vl[d]) event_seen(d, EV_VALID);
        chk($countones(st[d]) <= 1, "one_start_at_a_time", $countones(st[d]), 1);
        if (dn[d] && !dn_p[d]) done_rises[d]++;
        if (d == 0 && st_p[0][0] && !st[0][0]) norm_entry = cyc;
        if (d == 0 && er[0] && !er_p[0]) err_rise = cyc;
        st_p[d] = st[d];
        f_p[d]  = fb[d];
        dn_p[d] = dn[d];
        er_p[d] = er[d];
    endtask

    always @(negedge clk) begin
        cyc++;
        observe(0);
        observe(1);
    end

    function automatic bit cond(input int sel);
        case (sel)
            0:       return a_done;
            1:       return a_err;
            2:       return a_eig_s && (a_comp == 1'b1);
            3:       return a_defl_s;
            4:       return b_done;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_cond(input int sel, input int budget, input string name);
        int n = 0;
        while (!cond(sel) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(cond(sel), name, int'(cond(sel)), 1);
    endtask

    task automatic check_zero(input int d, input string name);
        chk(bz[d] == 1'b0, {name, "_busy"}, int'(bz[d]), 0);
        chk(dn[d] == 1'b0, {name, "_done"}, int'(dn[d]), 0);
        chk(er[d] == 1'b0, {name, "_err"}, int'(er[d]), 0);
        chk(ld[d] == 1'b0, {name, "_load_init"}, int'(ld[d]), 0);
        chk(vl[d] == 1'b0, {name, "_eig_valid"}, int'(vl[d]), 0);
        chk(st[d] == 4'b0, {name, "_starts"}, int'(st[d]), 0);
        chk(ci[d] == 0, {name, "_comp_idx"}, ci[d], 0);
        chk(ii[d] == 0, {name, "_iter_idx"}, ii[d], 0);
    endtask

    task automatic finish_run(input int d, input int sel, input int budget, input string name);
        wait_cond(sel, budget, name);
        @(negedge clk);
        chk(exp_q.size() == 0, {name, "_all_events"}, exp_q.size(), 0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int e = 0; e < 4; e++) begin
                lat[d][e] = 5; hold_len[d][e] = 0; never[d][e] = 1'b0;
            end
        end
        clear();
        rst = 1'b0; start_a = 1'b1; start_b = 1'b0;
        repeat (3) @(negedge clk);
        check_zero(0, "reset_a");
        check_zero(1, "reset_b");
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_zero(0, "held_start_no_run");

        // Nominal run: 2 components x 3 iterations
        start_a = 1'b0;
        @(negedge clk);
        clear();
        build(0, 2, 3, -1);
        start_a = 1'b1;
        finish_run(0, 0, 600, "nominal");
        chk(evcnt[0][EV_LOAD] == 2, "nominal_load_init", evcnt[0][EV_LOAD], 2);
        chk(evcnt[0][EV_MV] == 6, "nominal_mv", evcnt[0][EV_MV], 6);
        chk(evcnt[0][EV_NORM] == 6, "nominal_norm", evcnt[0][EV_NORM], 6);
        chk(evcnt[0][EV_VALID] == 2, "nominal_eig_valid", evcnt[0][EV_VALID], 2);
        chk(evcnt[0][EV_DEFL] == 1, "nominal_defl", evcnt[0][EV_DEFL], 1);
        chk(a_busy == 1'b0, "done_busy", int'(a_busy), 0);
        chk(a_comp == 1'b1, "done_comp_idx", int'(a_comp), 1);
        chk(a_iter == 2'd2, "done_iter_idx", int'(a_iter), 2);
        repeat (2) @(negedge clk);
        chk(a_done == 1'b1, "done_held", int'(a_done), 1);
        start_a = 1'b0;
        @(negedge clk);
        chk(a_done == 1'b0, "done_clears", int'(a_done), 0);

        // Slow return-to-zero on mv_f with a fast normaliser
        hold_len[0][0] = 4;
        lat[0][1] = 1;
        clear();
        build(0, 2, 3, -1);
        start_a = 1'b1;
        finish_run(0, 0, 800, "slow_rtz");
        chk(evcnt[0][EV_MV] == 6, "slow_rtz_mv", evcnt[0][EV_MV], 6);
        start_a = 1'b0;
        @(negedge clk);
        hold_len[0][0] = 0;
        lat[0][1] = 5;

        // Normaliser never answers
        never[0][1] = 1'b1;
        clear();
        build(0, 2, 3, 3);
        start_a = 1'b1;
        finish_run(0, 1, 200, "timeout");
        chk(err_rise - norm_entry == 20, "timeout_latency", err_rise - norm_entry, 20);
        chk(a_busy == 1'b0, "err_busy", int'(a_busy), 0);
        chk(st[0] == 4'b0, "err_starts", int'(st[0]), 0);
        chk(a_err == 1'b1, "err_held", int'(a_err), 1);
        start_a = 1'b0;
        @(negedge clk);
        chk(a_err == 1'b0, "err_clears", int'(a_err), 0);
        never[0][1] = 1'b0;
        repeat (3) @(negedge clk);

        // Abort during the second eigenvalue phase
        clear();
        build(0, 2, 3, 18);
        start_a = 1'b1;
        wait_cond(2, 600, "second_eig");
        start_a = 1'b0;
        @(negedge clk);
        chk(a_busy == 1'b0, "abort_busy", int'(a_busy), 0);
        chk(st[0] == 4'b0, "abort_starts", int'(st[0]), 0);
        repeat (20) @(negedge clk);
        chk(evcnt[0][EV_VALID] == 1, "abort_eig_valid", evcnt[0][EV_VALID], 1);
        chk(done_rises[0] == 0, "abort_no_done", done_rises[0], 0);
        chk(exp_q.size() == 0, "abort_all_events", exp_q.size(), 0);

        // Reset pulse during deflation, then restart
        clear();
        build(0, 2, 3, 10);
        start_a = 1'b1;
        wait_cond(3, 600, "defl_reached");
        rst = 1'b0;
        @(negedge clk);
        check_zero(0, "mid_defl_reset");
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk(a_busy == 1'b0, "no_restart_after_reset", int'(a_busy), 0);
        chk(evcnt[0][EV_LOAD] == 1, "reset_load_count", evcnt[0][EV_LOAD], 1);
        chk(exp_q.size() == 0, "reset_all_events", exp_q.size(), 0);
        start_a = 1'b0;
        @(negedge clk);
        clear();
        build(0, 2, 3, -1);
        start_a = 1'b1;
        finish_run(0, 0, 600, "restart");
        chk(evcnt[0][EV_VALID] == 2, "restart_eig_valid", evcnt[0][EV_VALID], 2);
        start_a = 1'b0;
        @(negedge clk);

        // Single component, single iteration
        clear();
        build(1, 1, 1, -1);
        start_b = 1'b1;
        finish_run(1, 4, 200, "single");
        chk(evcnt[1][EV_DEFL] == 0, "single_no_defl", evcnt[1][EV_DEFL], 0);
        chk(evcnt[1][EV_MV] == 1, "single_mv", evcnt[1][EV_MV], 1);
        chk(evcnt[1][EV_VALID] == 1, "single_eig_valid", evcnt[1][EV_VALID], 1);
        chk(b_done == 1'b1, "single_done", int'(b_done), 1);
        start_b = 1'b0;
        @(negedge clk);
        chk(b_done == 1'b0, "single_done_clears", int'(b_done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
